// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller side uses the master modport: it reads the opcode and the
// ALU zero flag, and drives the state, the strobes and the mux selects.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic [2:0] state;
  logic       PCWre;
  logic       IRWre;
  logic       RegWre;
  logic       mRD;
  logic       mWR;
  logic       ALUSrcA;
  logic       ALUSrcB;
  logic       ExtSel;
  logic       DBDataSrc;
  logic       WrRegDSrc;
  logic [1:0] RegDst;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [4:0] link_reg;
  logic       halted;

  modport master (
    input  opcode, zero,
    output state, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel,
           DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, link_reg, halted
  );

  modport slave (
    output opcode, zero,
    input  state, PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel,
           DBDataSrc, WrRegDSrc, RegDst, PCSrc, ALUOp, link_reg, halted
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control unit: steps each instruction through
// IF/ID/EXE/MEM/WB and decodes the strobes and selects for the datapath.
// Optional build macro MC_CTRL_INSN_CNT_EN adds a 32-bit retired-instruction
// counter output insn_cnt that counts every PC write.
// Strobes are decoded from the registered state plus the opcode: the opcode
// only becomes valid once IR has been loaded at the end of IF, so the ID-stage
// strobes of jumps cannot be precomputed a cycle earlier.
module multicycle_ctrl #(
  parameter logic [5:0] HALT_OP  = 6'b111111,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic CLK,
  input  logic Reset,
  multicycle_ctrl_if.master bus
`ifdef MC_CTRL_INSN_CNT_EN
  ,
  output logic [31:0] insn_cnt
`endif
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_L   = 3'b100,
    S_EXE_B  = 3'b101,
    S_EXE_R  = 3'b110,
    S_WB_R   = 3'b111
  } state_t;

  state_t     state;
  logic       halted;
  logic [2:0] alu_op_dec;
  logic       pcwre, irwre, regwre, mrd, mwr;
  logic       alusrca, alusrcb, extsel, dbdatasrc, wrregdsrc;
  logic [1:0] regdst, pcsrc;
  logic [2:0] aluop;

  logic is_j, is_jr, is_jal, is_jump, is_beq, is_bne, is_lw, is_sw, is_halt;
  logic is_sll, is_rtype;

  assign is_j     = (bus.opcode == OP_J);
  assign is_jr    = (bus.opcode == OP_JR);
  assign is_jal   = (bus.opcode == OP_JAL);
  assign is_jump  = is_j | is_jr | is_jal;
  assign is_beq   = (bus.opcode == OP_BEQ);
  assign is_bne   = (bus.opcode == OP_BNE);
  assign is_lw    = (bus.opcode == OP_LW);
  assign is_sw    = (bus.opcode == OP_SW);
  assign is_halt  = (bus.opcode == HALT_OP);
  assign is_sll   = (bus.opcode == OP_SLL);
  assign is_rtype = (bus.opcode == OP_ADD) | (bus.opcode == OP_SUB) |
                    (bus.opcode == OP_AND) | (bus.opcode == OP_SLT) | is_sll;

  // State sequencing and the sticky halt flag; once halted, only IF/ID loop.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IF;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IF:     state <= S_ID;
        S_ID: begin
          if (halted || is_jump || is_halt) begin
            state <= S_IF;
            if (is_halt) halted <= 1'b1;
          end else if (is_beq || is_bne) begin
            state <= S_EXE_B;
          end else if (is_lw || is_sw) begin
            state <= S_EXE_LS;
          end else begin
            state <= S_EXE_R;
          end
        end
        S_EXE_R:  state <= S_WB_R;
        S_EXE_LS: state <= S_MEM;
        S_MEM:    state <= is_lw ? S_WB_L : S_IF;
        default:  state <= S_IF;
      endcase
    end
  end

  // ALU function code for the current opcode; unknown opcodes add.
  always_comb begin
    alu_op_dec = 3'b000;
    case (bus.opcode)
      OP_SUB, OP_BEQ, OP_BNE: alu_op_dec = 3'b001;
      OP_SLL:                 alu_op_dec = 3'b010;
      OP_ORI:                 alu_op_dec = 3'b011;
      OP_AND:                 alu_op_dec = 3'b100;
      OP_SLT:                 alu_op_dec = 3'b110;
      default:                alu_op_dec = 3'b000;
    endcase
  end

  // Strobe and select decode; everything is forced to its idle value in reset.
  always_comb begin
    pcwre     = 1'b0;
    irwre     = 1'b0;
    regwre    = 1'b0;
    mrd       = 1'b0;
    mwr       = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 1'b0;
    extsel    = 1'b0;
    dbdatasrc = 1'b0;
    wrregdsrc = 1'b0;
    regdst    = 2'b01;
    pcsrc     = 2'b00;
    aluop     = 3'b000;
    if (Reset) begin
      if (state == S_IF) begin
        irwre = !halted;
      end else begin
        aluop     = alu_op_dec;
        alusrca   = is_sll;
        alusrcb   = (bus.opcode == OP_ADDIU) | (bus.opcode == OP_ORI) | is_lw | is_sw;
        extsel    = (bus.opcode == OP_ADDIU) | is_lw | is_sw | is_beq | is_bne;
        wrregdsrc = !is_jal;
        regdst    = is_jal ? 2'b00 : (is_rtype ? 2'b10 : 2'b01);
      end
      case (state)
        S_ID: begin
          if (!halted) begin
            if (is_j || is_jal) begin
              pcsrc = 2'b11;
              pcwre = 1'b1;
            end else if (is_jr) begin
              pcsrc = 2'b10;
              pcwre = 1'b1;
            end
            regwre = is_jal;
          end
        end
        S_EXE_B: begin
          pcwre = 1'b1;
          if ((is_beq && bus.zero) || (is_bne && !bus.zero)) pcsrc = 2'b01;
        end
        S_MEM: begin
          mrd       = is_lw;
          dbdatasrc = is_lw;
          mwr       = is_sw;
          pcwre     = !is_lw;
        end
        S_WB_L: begin
          regwre    = 1'b1;
          pcwre     = 1'b1;
          dbdatasrc = 1'b1;
        end
        S_WB_R: begin
          regwre = 1'b1;
          pcwre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state     = state;
  assign bus.halted    = halted;
  assign bus.PCWre     = pcwre;
  assign bus.IRWre     = irwre;
  assign bus.RegWre    = regwre;
  assign bus.mRD       = mrd;
  assign bus.mWR       = mwr;
  assign bus.ALUSrcA   = alusrca;
  assign bus.ALUSrcB   = alusrcb;
  assign bus.ExtSel    = extsel;
  assign bus.DBDataSrc = dbdatasrc;
  assign bus.WrRegDSrc = wrregdsrc;
  assign bus.RegDst    = regdst;
  assign bus.PCSrc     = pcsrc;
  assign bus.ALUOp     = aluop;
  assign bus.link_reg  = LINK_REG;

`ifdef MC_CTRL_INSN_CNT_EN
  // Count retired instructions: one per PC write, wrapping naturally.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) insn_cnt <= 32'd0;
    else if (pcwre) insn_cnt <= insn_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A per-instruction model derives the
// state path and the cycle on which each strobe fires from the instruction
// class; a single compare process checks the DUT on every falling edge.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLT   = 6'b100111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_UNK   = 6'b000111;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EXE_LS = 3'd2, ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB_L = 3'd4, ST_EXE_B = 3'd5, ST_EXE_R = 3'd6, ST_WB_R = 3'd7;

  typedef struct {
    logic [2:0] st;
    logic       pcwre, irwre, regwre, mrd, mwr, dbsrc, halted, wrsrc;
    logic       srca, srcb, ext;
    logic [1:0] pcsrc, regdst;
    logic [2:0] aluop;
    bit         chkpc, chkalu, chkwr;
  } exp_t;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  exp_t ex;
  bit   expvalid = 1'b0;
  bit   modelhalted = 1'b0;
  int   modelcnt = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl_if bus ();

`ifdef MC_CTRL_INSN_CNT_EN
  logic [31:0] insn_cnt;
  multicycle_ctrl dut (.CLK(CLK), .Reset(Reset), .bus(bus), .insn_cnt(insn_cnt));
`else
  multicycle_ctrl dut (.CLK(CLK), .Reset(Reset), .bus(bus));
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  function automatic logic [2:0] aluOpOf(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: return 3'b001;
      OP_SLL:                 return 3'b010;
      OP_ORI:                 return 3'b011;
      OP_AND:                 return 3'b100;
      OP_SLT:                 return 3'b110;
      default:                return 3'b000;
    endcase
  endfunction

  function automatic bit isRType(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT};
  endfunction

  // Compare the DUT against the current expectation on every falling edge
  initial begin
    forever begin
      @(negedge CLK);
      if (expvalid) begin
        checkOutput("state", bus.state, ex.st);
        checkOutput("PCWre", bus.PCWre, ex.pcwre);
        checkOutput("IRWre", bus.IRWre, ex.irwre);
        checkOutput("RegWre", bus.RegWre, ex.regwre);
        checkOutput("mRD", bus.mRD, ex.mrd);
        checkOutput("mWR", bus.mWR, ex.mwr);
        checkOutput("DBDataSrc", bus.DBDataSrc, ex.dbsrc);
        checkOutput("halted", bus.halted, ex.halted);
        if (ex.chkpc) checkOutput("PCSrc", bus.PCSrc, ex.pcsrc);
        if (ex.chkalu) begin
          checkOutput("ALUOp", bus.ALUOp, ex.aluop);
          checkOutput("ALUSrcA", bus.ALUSrcA, ex.srca);
          checkOutput("ALUSrcB", bus.ALUSrcB, ex.srcb);
          checkOutput("ExtSel", bus.ExtSel, ex.ext);
        end
        if (ex.chkwr) begin
          checkOutput("RegDst", bus.RegDst, ex.regdst);
          checkOutput("WrRegDSrc", bus.WrRegDSrc, ex.wrsrc);
        end
`ifdef MC_CTRL_INSN_CNT_EN
        checkOutput("insn_cnt", insn_cnt, modelcnt);
`endif
      end
    end
  end

  // Hold reset for two edges; the first cycle after release is checked by hand
  task automatic applyReset();
    Reset = 1'b0;
    modelcnt = 0;
    modelhalted = 1'b0;
    ex.st = ST_IF;
    {ex.pcwre, ex.irwre, ex.regwre, ex.mrd, ex.mwr, ex.dbsrc, ex.halted, ex.wrsrc} = '0;
    {ex.srca, ex.srcb, ex.ext} = '0;
    ex.pcsrc = 2'b00;
    ex.regdst = 2'b01;
    ex.aluop = 3'b000;
    ex.chkpc = 1'b1;
    ex.chkalu = 1'b1;
    ex.chkwr = 1'b1;
    expvalid = 1'b1;
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b1;
    #3;
    checkOutput("rel_state", bus.state, 3'b000);
    checkOutput("rel_IRWre", bus.IRWre, 1'b1);
    checkOutput("rel_PCWre", bus.PCWre, 1'b0);
    checkOutput("rel_halted", bus.halted, 1'b0);
  endtask

  // Run one instruction through the model; stop part-way if maxsteps is small
  task automatic applyStimulus(input logic [5:0] op, input logic z, input int litlen, input int maxsteps);
    logic [2:0] path [5];
    int n, pcstep, regstep, memstep;
    bit islw, issw, taken;
    islw = (op == OP_LW);
    issw = (op == OP_SW);
    pcstep = -1;
    regstep = -1;
    memstep = -1;
    path[0] = ST_IF;
    path[1] = ST_ID;
    if (modelhalted || op inside {OP_J, OP_JR, OP_JAL, OP_HALT}) begin
      n = 2;
      if (!modelhalted && op != OP_HALT) pcstep = 1;
      if (!modelhalted && op == OP_JAL) regstep = 1;
    end else if (op inside {OP_BEQ, OP_BNE}) begin
      n = 3; path[2] = ST_EXE_B; pcstep = 2;
    end else if (issw) begin
      n = 4; path[2] = ST_EXE_LS; path[3] = ST_MEM; pcstep = 3; memstep = 3;
    end else if (islw) begin
      n = 5; path[2] = ST_EXE_LS; path[3] = ST_MEM; path[4] = ST_WB_L;
      pcstep = 4; regstep = 4; memstep = 3;
    end else begin
      n = 4; path[2] = ST_EXE_R; path[3] = ST_WB_R; pcstep = 3; regstep = 3;
    end
    checkOutput("model_len", n, litlen);
    taken = (op == OP_BEQ && z) || (op == OP_BNE && !z);
    bus.opcode = op;
    bus.zero = z;
    expvalid = 1'b1;
    for (int k = 0; k < n; k++) begin
      ex.st     = path[k];
      ex.irwre  = (k == 0) && !modelhalted;
      ex.pcwre  = (k == pcstep);
      ex.regwre = (k == regstep);
      ex.mrd    = (k == memstep) && islw;
      ex.mwr    = (k == memstep) && issw;
      ex.dbsrc  = islw && (k == memstep || k == regstep);
      ex.halted = modelhalted;
      ex.chkpc  = !modelhalted;
      ex.pcsrc  = 2'b00;
      if (k == 1 && (op == OP_J || op == OP_JAL)) ex.pcsrc = 2'b11;
      if (k == 1 && op == OP_JR) ex.pcsrc = 2'b10;
      if (path[k] == ST_EXE_B && taken) ex.pcsrc = 2'b01;
      ex.chkalu = (k > 0);
      ex.aluop  = aluOpOf(op);
      ex.srca   = (op == OP_SLL);
      ex.srcb   = op inside {OP_ADDIU, OP_ORI, OP_LW, OP_SW};
      ex.ext    = op inside {OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE};
      ex.chkwr  = ex.regwre;
      ex.regdst = (op == OP_JAL) ? 2'b00 : (isRType(op) ? 2'b10 : 2'b01);
      ex.wrsrc  = (op != OP_JAL);
      if (k == maxsteps) begin
        @(negedge CLK);
        #1;
        return;
      end
      @(posedge CLK);
      #1;
      if (ex.pcwre) modelcnt++;
    end
    if (op == OP_HALT) modelhalted = 1'b1;
  endtask

  initial begin
    bus.opcode = OP_ADD;
    bus.zero = 1'b0;
    #2;
    applyReset();
    checkOutput("link_reg", bus.link_reg, 5'd31);
    // reset arrives in the middle of EXE_R of an add
    applyStimulus(OP_ADD, 1'b0, 4, 2);
    applyReset();
    applyStimulus(OP_ADD, 1'b0, 4, 99);
    applyStimulus(OP_LW, 1'b0, 5, 99);
    applyStimulus(OP_BEQ, 1'b1, 3, 99);
`ifdef MC_CTRL_INSN_CNT_EN
    checkOutput("cnt_after3", insn_cnt, 32'd3);
`endif
    applyStimulus(OP_BEQ, 1'b0, 3, 99);
    applyStimulus(OP_BNE, 1'b0, 3, 99);
    applyStimulus(OP_BNE, 1'b1, 3, 99);
    applyStimulus(OP_SW, 1'b0, 4, 99);
    applyStimulus(OP_JAL, 1'b0, 2, 99);
    applyStimulus(OP_J, 1'b0, 2, 99);
    applyStimulus(OP_JR, 1'b0, 2, 99);
    applyStimulus(OP_SUB, 1'b1, 4, 99);
    applyStimulus(OP_ADDIU, 1'b0, 4, 99);
    applyStimulus(OP_AND, 1'b0, 4, 99);
    applyStimulus(OP_ORI, 1'b0, 4, 99);
    applyStimulus(OP_SLL, 1'b0, 4, 99);
    applyStimulus(OP_SLT, 1'b0, 4, 99);
    applyStimulus(OP_UNK, 1'b0, 4, 99);
    applyStimulus(OP_HALT, 1'b0, 2, 99);
    // ten halted cycles checked by hand: PC and IR must stay frozen
    expvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checkOutput("halt_PCWre", bus.PCWre, 1'b0);
      checkOutput("halt_IRWre", bus.IRWre, 1'b0);
      checkOutput("halt_flag", bus.halted, 1'b1);
    end
    @(posedge CLK);
    #1;
    applyStimulus(OP_JAL, 1'b0, 2, 99);
    applyStimulus(OP_LW, 1'b0, 2, 99);
    applyStimulus(OP_J, 1'b0, 2, 99);
    applyReset();
    applyStimulus(OP_ADD, 1'b0, 4, 99);
    expvalid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequential control unit for the multi-cycle CPU variant.
- Decodes the 6-bit opcode and steps each instruction through the IF/ID/EXE/MEM/WB states.
- Drives the ALU's ALUOp, ALUSrcA and ALUSrcB, plus the PC, IR, register-file and data-memory enables.
- Consumes the ALU's zero flag to resolve branches.

Parameters:
- HALT_OP, 6'b111111, opcode that stops the machine.
- LINK_REG, 5'd31, register written by jal (exported on link_reg).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26].
- zero  in  1  ALU zero flag.
- state  out  3  current FSM state.
- PCWre  out  1  PC write enable.
- IRWre  out  1  instruction register write enable.
- RegWre  out  1  register file write enable.
- mRD  out  1  data memory read strobe.
- mWR  out  1  data memory write strobe.
- ALUSrcA  out  1  0=rs data, 1=sa.
- ALUSrcB  out  1  0=rt data, 1=extended immediate.
- ExtSel  out  1  0=zero-extend, 1=sign-extend.
- DBDataSrc  out  1  0=ALU result, 1=memory data.
- WrRegDSrc  out  1  0=PC+4 (link), 1=DB.
- RegDst  out  2  00=LINK_REG, 01=rt, 10=rd.
- PCSrc  out  2  00=PC+4, 01=branch target, 10=rs (jr), 11=jump target.
- ALUOp  out  3  ALU function code.
- link_reg  out  5  constant LINK_REG.
- halted  out  1  sticky halt flag.

Behaviour:
- Opcodes: add 000000, sub 000001, addiu 000010, and 010000, ori 010010, sll 011000, slt 100111, sw 110000, lw 110001, beq 110100, bne 110101, j 111000, jr 111001, jal 111010, halt = HALT_OP.
- ALUOp mapping:
  - 000 for add, addiu, lw, sw.
  - 001 for sub, beq, bne.
  - 010 for sll (B<<A, ALUSrcA=1).
  - 011 for ori; 100 for and; 110 for slt (signed).
  - Unknown opcode: ALUOp=000.
- ExtSel=1 for addiu, lw, sw, beq, bne; 0 otherwise.
- ALUSrcB=1 for addiu, ori, lw, sw.
- States: IF=000, ID=001, EXE_LS=010, MEM=011, WB_L=100, EXE_B=101, EXE_R=110, WB_R=111.
- Transitions:
  - IF -> ID.
  - ID:
    - j/jr/jal -> IF.
    - beq/bne -> EXE_B.
    - lw/sw -> EXE_LS.
    - halt -> IF with halted set.
    - All others, including unknown -> EXE_R.
  - EXE_R -> WB_R -> IF.
  - EXE_B -> IF.
  - EXE_LS -> MEM.
  - MEM: sw -> IF, lw -> WB_L.
  - WB_L -> IF.
- Strobes (Moore on state, with opcode qualification):
  - IRWre=1 only in IF.
  - PCWre=1 only in the final state of each instruction (ID for j/jr/jal; EXE_B; MEM for sw; WB_R; WB_L). Never 1 when halted, or in ID for halt.
  - RegWre=1 in WB_R, in WB_L, and in ID for jal (RegDst=00, WrRegDSrc=0).
  - mRD=1 in MEM for lw; mWR=1 in MEM for sw.
  - DBDataSrc=1 only in WB_L and MEM for lw.
- PCSrc:
  - 01 in EXE_B when (beq and zero=1) or (bne and zero=0), else 00.
  - 11 for j/jal; 10 for jr.
- Halt: once halted=1, FSM cycles IF/ID with PCWre=IRWre=RegWre=mWR=0, so PC and IR are frozen. Only Reset clears halted.
- Reset low, at any time and mid-instruction:
  - state=IF, halted=0, all enables=0.
  - ALUOp=000, PCSrc=00, RegDst=01, other selects 0.
  - First IRWre pulse in the first IF after release.
- ALUOp, ALUSrcA, ALUSrcB and ExtSel are held valid from ID through the last state, so ALU inputs are stable for the combinational ALU.
- Per-instruction cycles: j/jr/jal/halt 2, beq/bne 3, sw 4, R/imm 4, lw 5.

Optional Feature:
- Macro MC_CTRL_INSN_CNT_EN.
- Defined: adds output insn_cnt[31:0].
  - Reset to 0.
  - Increments by 1 on every clock edge where PCWre=1.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port absent, no counter logic.

Test Plan:
- Reset low mid-EXE_R, release -> state=000, IRWre=1, PCWre=0, halted=0 on first cycle.
- opcode=000000 (add) -> states 000,001,110,111,000; ALUOp=000; RegWre=1 and PCWre=1 only in 111; RegDst=10.
- opcode=110001 (lw) -> 5 cycles via 010,011,100; mRD=1 in 011; ALUSrcB=1, ExtSel=1; RegWre=1 in 100 with DBDataSrc=1.
- opcode=110100 (beq):
  - zero=1 -> PCSrc=01 and PCWre=1 in 101.
  - Repeat with zero=0 -> PCSrc=00.
  - opcode=110101 (bne) with zero=0 -> PCSrc=01.
- opcode=111010 (jal) -> 2 cycles; in ID RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- opcode=111111 -> halted=1; next 10 cycles PCWre=IRWre=0. With MC_CTRL_INSN_CNT_EN, insn_cnt holds (e.g. 3 after add, lw, beq), then Reset low clears both.
